// File: rtl/cfs_cdc_pkg.sv
// Shared constants for the cfs toggle-handshake CDC sender/receiver pair.
// FSM state encoding and the legal synchroniser depth range.
package cfs_cdc_pkg;

    localparam logic CFS_CDC_IDLE     = 1'b0;
    localparam logic CFS_CDC_WAIT_ACK = 1'b1;

    localparam int CFS_CDC_SYNC_STAGES_MIN = 2;
    localparam int CFS_CDC_SYNC_STAGES_MAX = 4;

    // Out-of-range depths are pulled to the nearest legal value.
    function automatic int cfs_cdc_clamp_stages(input int n);
        if (n < CFS_CDC_SYNC_STAGES_MIN) return CFS_CDC_SYNC_STAGES_MIN;
        if (n > CFS_CDC_SYNC_STAGES_MAX) return CFS_CDC_SYNC_STAGES_MAX;
        return n;
    endfunction

endpackage

// File: rtl/cfs_synch.sv
// One synchroniser flop stage; chained by the parent to build a multi-flop
// synchroniser for a foreign-domain signal.
module cfs_synch #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else          q <= d;
    end

endmodule

// File: rtl/cfs_cdc_tx.sv
// Source side of a 2-phase req/ack CDC: holds one word on tx_data, toggles tx_req,
// frees itself on the synchronised tx_ack toggle. Optional CFS_CDC_TX_TIMEOUT_EN.
module cfs_cdc_tx
    import cfs_cdc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
`ifdef CFS_CDC_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic                  busy,
    output logic                  tx_req,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ack
`ifdef CFS_CDC_TX_TIMEOUT_EN
    ,
    output logic                  timeout
`endif
);

    localparam int STAGES = cfs_cdc_clamp_stages(SYNC_STAGES);

    logic              state_q, state_d;
    logic [STAGES:0]   ack_chain;
    logic              ack_sync;
    logic              accept;

    // Only the last flop of the chain is ever looked at.
    assign ack_chain[0] = tx_ack;
    assign ack_sync     = ack_chain[STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_sync
        cfs_synch #(.DATA_WIDTH(1)) u_synch (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (ack_chain[g]),
            .q       (ack_chain[g+1])
        );
    end

    assign accept = (state_q == CFS_CDC_IDLE) && valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= CFS_CDC_IDLE;
        else          state_q <= state_d;
    end

    // A mismatching ack seen in IDLE is spurious and simply ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CFS_CDC_IDLE:     if (valid)              state_d = CFS_CDC_WAIT_ACK;
            CFS_CDC_WAIT_ACK: if (ack_sync == tx_req) state_d = CFS_CDC_IDLE;
            default:                                  state_d = CFS_CDC_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        case (state_q)
            CFS_CDC_IDLE:     ready = 1'b1;
            CFS_CDC_WAIT_ACK: ready = 1'b0;
            default:          ready = 1'b0;
        endcase
        busy = ~ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_req  <= 1'b0;
            tx_data <= '0;
        end else if (accept) begin
            tx_req  <= ~tx_req;
            tx_data <= data;
        end
    end

`ifdef CFS_CDC_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;

    // Flag rises on the edge that completes the TIMEOUT_CYCLES-th wait cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (accept)
                wait_cnt <= '0;
            else if (state_q == CFS_CDC_WAIT_ACK && wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            if (state_q == CFS_CDC_WAIT_ACK && wait_cnt == CNT_LAST)
                timeout <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cfs_cdc_tx.sv
// Directed bench for cfs_cdc_tx; receiver modelled as a 5-clk tx_req->tx_ack loopback.
// The timeout scenario runs only when CFS_CDC_TX_TIMEOUT_EN is defined.
module tb_cfs_cdc_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic        ready, busy, tx_req, tx_ack;
    logic [31:0] tx_data;
`ifdef CFS_CDC_TX_TIMEOUT_EN
    logic        timeout;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] ack_dly;
    logic       ack_en = 1'b1;
    logic       ack_force = 1'b0;
    logic       ack_fval = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)    ack_dly <= '0;
        else if (ack_en) ack_dly <= {ack_dly[3:0], tx_req};
    end
    assign tx_ack = ack_force ? ack_fval : ack_dly[4];

    cfs_cdc_tx #(
        .DATA_WIDTH     (32),
        .SYNC_STAGES    (2)
`ifdef CFS_CDC_TX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (valid),
        .data    (data),
        .ready   (ready),
        .busy    (busy),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .tx_ack  (tx_ack)
`ifdef CFS_CDC_TX_TIMEOUT_EN
        ,
        .timeout (timeout)
`endif
    );

    task automatic test_reset();
        reset_n = 1'b0;
        valid   = 1'b1;
        data    = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
            n_cmp++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", tx_req); end
            n_cmp++; if (tx_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", tx_data); end
        end
        valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (tx_req !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL reset_release: got req=%b rdy=%b want req=0 rdy=1", tx_req, ready); end
    endtask

    task automatic test_single();
        int cyc, ack_at, rdy_at;
        logic prev_ack;
        valid = 1'b1;
        data  = 32'hA5A5_0001;
        @(negedge clk);
        valid = 1'b0;
        n_cmp++; if (tx_req !== 1'b1) begin n_err++; $display("FAIL single_req: got %b want 1", tx_req); end
        n_cmp++; if (tx_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_data: got %h want a5a50001", tx_data); end
        n_cmp++; if (ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got rdy=%b busy=%b want rdy=0 busy=1", ready, busy); end
        cyc = 1; ack_at = 0; rdy_at = 0; prev_ack = tx_ack;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (ack_at == 0 && tx_ack !== prev_ack) ack_at = cyc;
            if (ready === 1'b1) begin rdy_at = cyc; break; end
        end
        n_cmp++; if (rdy_at != 9) begin n_err++; $display("FAIL single_roundtrip: got %0d clk want 9", rdy_at); end
        n_cmp++; if (rdy_at - ack_at != 3) begin n_err++; $display("FAIL single_ack_to_ready: got %0d clk want 3", rdy_at - ack_at); end
    endtask

    task automatic test_hold();
        valid = 1'b1;
        data  = 32'hA5A5_0001;
        @(negedge clk);
        n_cmp++; if (tx_req !== 1'b0 || tx_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL hold_accept: got req=%b data=%h want req=0 data=a5a50001", tx_req, tx_data); end
        data = 32'h1234_5678;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            n_cmp++; if (tx_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL hold_data c%0d: got %h want a5a50001", i, tx_data); end
            n_cmp++; if (tx_req !== 1'b0 || ready !== 1'b0) begin n_err++; $display("FAIL hold_req c%0d: got req=%b rdy=%b want req=0 rdy=0", i, tx_req, ready); end
        end
        valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1 || tx_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL hold_release: got rdy=%b data=%h want rdy=1 data=a5a50001", ready, tx_data); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic prev, exp_req;
        exp_req = 1'b0;
        valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            data = 32'(k);
            prev = tx_req;
            exp_req = ~exp_req;
            cyc = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                cyc++;
                if (tx_req !== prev) break;
            end
            n_cmp++; if (tx_req !== exp_req) begin n_err++; $display("FAIL b2b_req w%0d: got %b want %b", k, tx_req, exp_req); end
            n_cmp++; if (tx_data !== 32'(k)) begin n_err++; $display("FAIL b2b_data w%0d: got %h want %h", k, tx_data, 32'(k)); end
            n_cmp++; if (cyc != ((k == 1) ? 1 : 9)) begin n_err++; $display("FAIL b2b_spacing w%0d: got %0d want %0d", k, cyc, (k == 1) ? 1 : 9); end
        end
        valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
        end
        n_cmp++; if (ready !== 1'b1 || tx_data !== 32'h3) begin n_err++; $display("FAIL b2b_drain: got rdy=%b data=%h want rdy=1 data=3", ready, tx_data); end
    endtask

    task automatic test_spurious();
        logic r;
        r = tx_req;
        ack_fval  = ~tx_req;
        ack_force = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (ready !== 1'b1 || tx_req !== r) begin n_err++; $display("FAIL spurious c%0d: got rdy=%b req=%b want rdy=1 req=%b", i, ready, tx_req, r); end
        end
        ack_force = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        valid = 1'b1;
        data  = 32'h55;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
        end
        n_cmp++; if (tx_req !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL mid_prep: got req=%b rdy=%b want req=0 rdy=1", tx_req, ready); end
        valid = 1'b1;
        data  = 32'h66;
        @(negedge clk);
        n_cmp++; if (tx_req !== 1'b1 || ready !== 1'b0) begin n_err++; $display("FAIL mid_accept: got req=%b rdy=%b want req=1 rdy=0", tx_req, ready); end
        data = 32'h77;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (tx_req !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL mid_async: got req=%b rdy=%b busy=%b want 0/1/0", tx_req, ready, busy); end
        n_cmp++; if (tx_data !== 32'h0) begin n_err++; $display("FAIL mid_async_data: got %h want 0", tx_data); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (tx_req !== 1'b0 || tx_data !== 32'h0) begin n_err++; $display("FAIL mid_held c%0d: got req=%b data=%h want 0/0", i, tx_req, tx_data); end
        end
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        valid = 1'b0;
        n_cmp++; if (tx_req !== 1'b1 || tx_data !== 32'h77) begin n_err++; $display("FAIL mid_post_accept: got req=%b data=%h want 1/77", tx_req, tx_data); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
        end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_drain: got rdy=%b want 1", ready); end
    endtask

`ifdef CFS_CDC_TX_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        ack_en = 1'b0;
        valid  = 1'b1;
        data   = 32'h99;
        @(negedge clk);
        valid = 1'b0;
        n_cmp++; if (tx_req !== 1'b1 || timeout !== 1'b0) begin n_err++; $display("FAIL to_accept: got req=%b to=%b want 1/0", tx_req, timeout); end
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);
            n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_early c%0d: got %b want 0", i, timeout); end
        end
        @(negedge clk);
        n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_set: got %b want 1", timeout); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (timeout !== 1'b1 || ready !== 1'b0) begin n_err++; $display("FAIL to_sticky c%0d: got to=%b rdy=%b want 1/0", i, timeout, ready); end
        end
        ack_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
        end
        n_cmp++; if (ready !== 1'b1 || timeout !== 1'b1) begin n_err++; $display("FAIL to_late_ack: got rdy=%b to=%b want 1/1", ready, timeout); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_reset: got %b want 0", timeout); end
        @(negedge clk) reset_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
`ifdef CFS_CDC_TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
